// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC controller.
// Drives a binary-search trial code onto the R2R DAC and holds each trial for
// SETTLE_CYCLES clocks. It then samples the synchronized comparator in a
// one-cycle DECIDE step to resolve that bit. A finished conversion is
// delivered as a one-cycle ready pulse, with result valid in the same cycle.
module sar_adc_controller #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             continuous,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t           state_reg,   state_next;
  logic [WIDTH-1:0] code_reg,    code_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic             ready_reg,   ready_next;
  logic             busy_reg,    busy_next;

  // One-hot decode of the bit currently under test.
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] next_bit_sel;
  logic [WIDTH-1:0] resolved_code;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // The next trial bit sits directly below the current one. The current bit
  // is kept only if the input is at or above the trial level.
  assign next_bit_sel  = bit_sel >> 1;
  assign resolved_code = comp_in ? code_reg : (code_reg & ~bit_sel);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      code_reg    <= '0;
      bit_idx_reg <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      code_reg    <= code_next;
      bit_idx_reg <= bit_idx_next;
      cnt_reg     <= cnt_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
    end
  end

  // Next-state logic: binary search, settling count, and abort handling.
  always_comb begin
    state_next   = state_reg;
    code_next    = code_reg;
    bit_idx_next = bit_idx_reg;
    cnt_next     = cnt_reg;
    result_next  = result_reg;
    ready_next   = 1'b0;
    busy_next    = busy_reg;

    case (state_reg)
      IDLE: begin
        // The final code stays on the DAC while idle.
        if (enable && (start || continuous)) begin
          state_next   = SETTLE;
          code_next    = CODE_MSB;
          bit_idx_next = IDX_TOP;
          cnt_next     = '0;
          busy_next    = 1'b1;
        end
      end

      SETTLE: begin
        if (!enable) begin
          state_next = IDLE;
          code_next  = '0;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DECIDE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DECIDE: begin
        // An abort wins over completing the last bit.
        if (!enable) begin
          state_next = IDLE;
          code_next  = '0;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end else if (bit_idx_reg != '0) begin
          state_next   = SETTLE;
          code_next    = resolved_code | next_bit_sel;
          bit_idx_next = bit_idx_reg - IDX_W'(1);
          cnt_next     = '0;
        end else begin
          state_next  = IDLE;
          code_next   = resolved_code;
          result_next = resolved_code;
          ready_next  = 1'b1;
          busy_next   = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        code_next  = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign dac_code = code_reg;
  assign result   = result_reg;
  assign ready    = ready_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed testbench for sar_adc_controller (WIDTH=8, SETTLE_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge. The
// comparator is modelled as comp_in = (vin >= dac_code), or it is tied high
// or low for the extreme cases.
module tb_sar_adc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       comp_in;
  logic [7:0] dac_code;
  logic [7:0] result;
  logic       ready;
  logic       busy;

  logic [7:0] vin = 8'h00;
  int         comp_mode = 0;  // 0: model, 1: tied high, 2: tied low

  int checks = 0;
  int errors = 0;

  sar_adc_controller #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .continuous (continuous),
    .comp_in    (comp_in),
    .dac_code   (dac_code),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    comp_in = 1'b0;
    if (comp_mode == 1)      comp_in = 1'b1;
    else if (comp_mode == 0) comp_in = (vin >= dac_code);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start for one edge; on return the bench sits in the first cycle
  // after the request edge.
  task automatic start_conv();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Counts cycles from the current one until ready is seen (bounded).
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 200) begin
      step(1);
      lat++;
    end
  endtask

  logic [7:0] trial_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] sweep [3]    = '{8'h10, 8'h11, 8'h10};

  initial begin
    int lat;
    int busy_low;
    int ready_cnt;
    logic [7:0] prev_result;

    // ---------------- reset with random inputs ----------------
    step(1);
    for (int i = 0; i < 3; i++) begin
      reset      = 1'b1;
      enable     = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      continuous = 1'($urandom_range(0, 1));
      vin        = 8'($urandom_range(0, 255));
      step(1);
      check("rst_dac",    {24'b0, dac_code}, 32'h0);
      check("rst_result", {24'b0, result},   32'h0);
      check("rst_ready",  {31'b0, ready},    32'h0);
      check("rst_busy",   {31'b0, busy},     32'h0);
    end
    $display("reset: 3 cycles, outputs cleared");
    start = 1'b0; continuous = 1'b0; enable = 1'b1; vin = 8'h00;
    reset = 1'b0;
    step(2);
    check("idle_busy", {31'b0, busy}, 32'h0);

    // ---------------- single conversion vin=0xA5 ----------------
    vin = 8'hA5; comp_mode = 0;
    start_conv();
    check("single_busy_rise", {31'b0, busy}, 32'h1);
    for (int n = 0; n < 40; n++) begin
      check($sformatf("trial_n%0d", n), {24'b0, dac_code}, {24'b0, trial_a5[n/5]});
      check($sformatf("noready_n%0d", n), {31'b0, ready}, 32'h0);
      step(1);
    end
    check("single_ready",  {31'b0, ready},  32'h1);
    check("single_result", {24'b0, result}, 32'hA5);
    check("single_busy_fall", {31'b0, busy}, 32'h0);
    $display("single: vin=0x%0h result=0x%0h", vin, result);
    step(1);
    check("single_ready_once", {31'b0, ready}, 32'h0);
    check("single_dac_hold", {24'b0, dac_code}, 32'hA5);

    // ---------------- extremes ----------------
    comp_mode = 1;
    start_conv();
    wait_ready(lat);
    check("ext_hi_lat",    lat,              40);
    check("ext_hi_result", {24'b0, result},  32'hFF);
    $display("extreme high: latency=%0d result=0x%0h", lat, result);
    step(1);
    comp_mode = 2;
    start_conv();
    wait_ready(lat);
    check("ext_lo_lat",    lat,              40);
    check("ext_lo_result", {24'b0, result},  32'h00);
    $display("extreme low: latency=%0d result=0x%0h", lat, result);
    step(1);

    // ---------------- continuous mode ----------------
    comp_mode = 0;
    vin = sweep[0];
    continuous = 1'b1;
    step(1);
    wait_ready(lat);
    check("cont_first_lat", lat, 40);
    check("cont_res0", {24'b0, result}, {24'b0, sweep[0]});
    $display("continuous: conv 0 vin=0x%0h result=0x%0h latency=%0d", vin, result, lat);
    for (int k = 1; k < 3; k++) begin
      vin = sweep[k];
      if (k == 2) continuous = 1'b0;  // stays on for this conversion; cleared below
      continuous = 1'b1;
      lat = 0;
      busy_low = 0;
      step(1);
      lat = 1;
      while (!ready && lat < 200) begin
        if (!busy) busy_low++;
        // Extra start requests while busy must be ignored.
        start = (lat == 10 || lat == 39) ? 1'b1 : 1'b0;
        step(1);
        lat++;
      end
      start = 1'b0;
      check($sformatf("cont_period%0d", k), lat, 41);
      check($sformatf("cont_res%0d", k), {24'b0, result}, {24'b0, sweep[k]});
      check($sformatf("cont_busy_low%0d", k), busy_low, 0);
      check($sformatf("cont_busy_ready%0d", k), {31'b0, busy}, 32'h0);
      $display("continuous: conv %0d vin=0x%0h result=0x%0h period=%0d", k, vin, result, lat);
    end
    continuous = 1'b0;
    step(1);
    check("cont_stop_busy", {31'b0, busy}, 32'h0);
    check("cont_stop_dac",  {24'b0, dac_code}, 32'h10);
    step(1);

    // ---------------- abort via enable ----------------
    prev_result = result;
    vin = 8'h5A;
    start_conv();
    step(15);
    enable = 1'b0;
    step(1);
    check("abort_busy",   {31'b0, busy},     32'h0);
    check("abort_dac",    {24'b0, dac_code}, 32'h0);
    check("abort_ready",  {31'b0, ready},    32'h0);
    check("abort_result", {24'b0, result},   {24'b0, prev_result});
    ready_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (ready) ready_cnt++;
      step(1);
    end
    check("abort_no_ready", ready_cnt, 0);
    $display("abort(enable): result held at 0x%0h", result);
    enable = 1'b1;

    // ---------------- abort via reset ----------------
    start_conv();
    step(15);
    reset = 1'b1;
    step(1);
    check("rabort_busy",   {31'b0, busy},     32'h0);
    check("rabort_dac",    {24'b0, dac_code}, 32'h0);
    check("rabort_ready",  {31'b0, ready},    32'h0);
    check("rabort_result", {24'b0, result},   32'h0);
    reset = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (ready) ready_cnt++;
      step(1);
    end
    check("rabort_no_ready", ready_cnt, 0);
    $display("abort(reset): outputs cleared");

    // ---------------- enable falls in final DECIDE ----------------
    vin = 8'h77;
    start_conv();
    wait_ready(lat);
    check("pre_bound_result", {24'b0, result}, 32'h77);
    prev_result = result;
    step(1);
    vin = 8'h33;
    start_conv();
    step(39);  // now in the last DECIDE cycle
    enable = 1'b0;
    step(1);
    check("bound_ready",  {31'b0, ready},    32'h0);
    check("bound_result", {24'b0, result},   {24'b0, prev_result});
    check("bound_busy",   {31'b0, busy},     32'h0);
    check("bound_dac",    {24'b0, dac_code}, 32'h0);
    ready_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready) ready_cnt++;
      step(1);
    end
    check("bound_no_ready", ready_cnt, 0);
    enable = 1'b1;
    start_conv();
    wait_ready(lat);
    check("bound_rerun_lat",    lat,             40);
    check("bound_rerun_result", {24'b0, result}, 32'h33);
    $display("boundary: rerun latency=%0d result=0x%0h", lat, result);
    step(1);
    check("bound_rerun_ready_once", {31'b0, ready}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
